// File: rtl/alu_share_pkg.sv
// Shared definitions for the alu_share_ctrl slice: FSM states, ALU selects, wait-counter width.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_HALF = 3'b100;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/alu_share_arb.sv
// Combinational one-hot grant for the shared ALU.
// ALU_SHARE_RR_EN selects round-robin from ptr_i; otherwise fixed priority, lowest index wins.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid_i,
`ifdef ALU_SHARE_RR_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [N_REQ-1:0] grant_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef ALU_SHARE_RR_EN
      idx = IDX_W'((32'(ptr_i) + k) % N_REQ);
`else
      idx = IDX_W'(k);
`endif
      if (!found && req_valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external signed ALU among N_REQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_SHARE_RR_EN: round-robin arbitration instead of fixed priority.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned W_ALU_SEL = 3,
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MUL_LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ*W_ALU_SEL-1:0] req_sel,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_flag_n,
  output logic                       rsp_flag_c,
  output logic [WIDTH-1:0]           alu_bus_a,
  output logic [WIDTH-1:0]           alu_bus_b,
  output logic [W_ALU_SEL-1:0]       alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       alu_flag_n,
  input  logic                       alu_flag_c,
  output logic                       busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, data_q, data_d;
  logic [W_ALU_SEL-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]       g_q, g_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fn_q, fn_d, fc_q, fc_d;
  logic [N_REQ-1:0]       grant;

`ifdef ALU_SHARE_RR_EN
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  alu_share_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_valid_i (req_valid),
`ifdef ALU_SHARE_RR_EN
    .ptr_i       (ptr_q),
`endif
    .grant_o     (grant)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fn_q    <= 1'b0;
      fc_q    <= 1'b0;
`ifdef ALU_SHARE_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fn_q    <= fn_d;
      fc_q    <= fc_d;
`ifdef ALU_SHARE_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    fn_d      = fn_q;
    fc_d      = fc_q;
`ifdef ALU_SHARE_RR_EN
    ptr_d     = ptr_q;
`endif
    req_ready = '0;
    rsp_valid = '0;
    alu_bus_a = '0;
    alu_bus_b = '0;
    alu_sel   = W_ALU_SEL'(ALU_PASS);

    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              a_d   = req_a[i*WIDTH +: WIDTH];
              b_d   = req_b[i*WIDTH +: WIDTH];
              sel_d = req_sel[i*W_ALU_SEL +: W_ALU_SEL];
              g_d   = IDX_W'(i);
            end
          end
          cnt_d   = (sel_d == W_ALU_SEL'(ALU_MUL)) ? CNT_W'(MUL_LAT - 1) : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_bus_a = a_q;
        alu_bus_b = b_q;
        alu_sel   = sel_q;
        if (cnt_q == '0) begin
          data_d  = alu_out;
          fn_d    = alu_flag_n;
          fc_d    = alu_flag_c;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        // Only the owning requester's rsp_ready can retire the response.
        if (rsp_ready[g_q]) begin
          state_d = IDLE;
`ifdef ALU_SHARE_RR_EN
          ptr_d = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data   = data_q;
  assign rsp_flag_n = fn_q;
  assign rsp_flag_c = fc_q;
  assign busy       = (state_q != IDLE);

endmodule
